// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);
  localparam int MUL_ACC_W = 2 * MUL_WIDTH + 1;

  typedef logic [2*MUL_WIDTH-1:0] mul_product_t;

endpackage

// File: rtl/mul_bit_counter.sv
// Shift counter for the multiplier loop; K marks the shift that completes the product.
module mul_bit_counter
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Load,
  input  logic Sh,
  output logic K
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt_q;

  // Load clears ahead of Sh; the count wraps freely past the last shift.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else if (Load) begin
      cnt_q <= '0;
    end else if (Sh) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign K = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_shift_add_datapath.sv
// Datapath of the shift-and-add multiplier: multiplicand, accumulator/multiplier
// register and bit counter, driven by Load/Ad/Sh strobes from the control FSM.
module mul_shift_add_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Load,
  input  logic                 Ad,
  input  logic                 Sh,
  input  logic [WIDTH-1:0]     Mcand,
  input  logic [WIDTH-1:0]     Mplier,
  output logic                 M,
  output logic                 K,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int ACC_W = 2 * WIDTH + 1;

  logic [WIDTH-1:0] mcand_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_add;
  logic [ACC_W-1:0] acc_d;
  logic [WIDTH:0]   add_sum;

  // The add keeps its carry in bit 2W so a following shift brings it into the product.
  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    acc_add = Ad ? {add_sum, acc_q[WIDTH-1:0]} : acc_q;
    acc_d   = acc_q;
    if (Load) begin
      acc_d = {{(WIDTH+1){1'b0}}, Mplier};
    end else if (Sh) begin
      acc_d = acc_add >> 1;
    end else begin
      acc_d = acc_add;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      if (Load) begin
        mcand_q <= Mcand;
      end
      acc_q <= acc_d;
    end
  end

  mul_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Load  (Load),
    .Sh    (Sh),
    .K     (K)
  );

  assign M       = acc_q[0];
  assign Product = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_mul_shift_add_datapath.sv
// Directed bench for mul_shift_add_datapath, acting as the control FSM.
module tb_mul_shift_add_datapath;
  import mul_pkg::*;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic           load;
  logic           ad;
  logic           sh;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           m;
  logic           k;
  mul_product_t   product;

  int tests_run = 0;
  int failures  = 0;

  typedef struct {
    string        name;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic [2*W-1:0] product;
  } vec_t;

  vec_t vecs[7];

  mul_shift_add_datapath #(.WIDTH(W)) dut (
    .Clk     (clk),
    .Rst_n   (rst_n),
    .Load    (load),
    .Ad      (ad),
    .Sh      (sh),
    .Mcand   (mcand),
    .Mplier  (mplier),
    .M       (m),
    .K       (k),
    .Product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                             input logic [2*W-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadOperands(input logic [W-1:0] a, input logic [W-1:0] b);
    mcand  = a;
    mplier = b;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  // One S1 (Ad if M) plus one S2 (Sh) iteration; reports K seen during the shift.
  task automatic loopIteration(output logic k_seen, output logic m_seen);
    m_seen = m;
    ad     = m;
    sh     = 1'b0;
    tick();
    ad     = 1'b0;
    sh     = 1'b1;
    k_seen = k;
    tick();
    sh     = 1'b0;
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               output int shifts_at_k, output int k_count,
                               output int ad_count, output bit done);
    logic k_seen;
    logic m_seen;
    int   shifts;
    loadOperands(a, b);
    shifts     = 0;
    shifts_at_k = 0;
    k_count    = 0;
    ad_count   = 0;
    done       = 1'b0;
    for (int it = 0; it < 2 * W + 4 && !done; it++) begin
      loopIteration(k_seen, m_seen);
      shifts++;
      if (m_seen) ad_count++;
      if (k_seen) begin
        k_count++;
        shifts_at_k = shifts;
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int   shifts_at_k;
    int   k_count;
    int   ad_count;
    bit   done;
    logic k_seen;
    logic m_seen;

    vecs[0] = '{"3x5",          32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    vecs[1] = '{"max x max",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{"zero mplier",  32'hDEAD_BEEF, 32'h0000_0000, 64'h0000_0000_0000_0000};
    vecs[3] = '{"msb x msb",    32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[4] = '{"1 x max",      32'h0000_0001, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{"2^16 x 2^16",  32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    vecs[6] = '{"max x 2",      32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE};

    rst_n  = 1'b0;
    load   = 1'b0;
    ad     = 1'b0;
    sh     = 1'b0;
    mcand  = '0;
    mplier = '0;

    // Reset then idle.
    tick();
    tick();
    checkOutput("reset product", product, '0);
    checkOutput("reset M", 64'(m), 64'd0);
    checkOutput("reset K", 64'(k), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("idle product", product, '0);
    checkOutput("idle K", 64'(k), 64'd0);

    // Table of full multiplications under the reference control sequence.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].mcand, vecs[i].mplier, shifts_at_k, k_count, ad_count, done);
      if (!done) begin
        tests_run++;
        failures++;
        $display("[TB] FAIL %s timeout: K never seen within %0d iterations", vecs[i].name, 2 * W + 4);
      end
      checkOutput({vecs[i].name, " product"}, product, vecs[i].product);
      checkOutput({vecs[i].name, " K shift index"}, 64'(shifts_at_k), 64'(W));
      checkOutput({vecs[i].name, " Ad count"}, 64'(ad_count), 64'($countones(vecs[i].mplier)));
      checkOutput({vecs[i].name, " K after done"}, 64'(k), 64'd0);
      tick();
      tick();
      checkOutput({vecs[i].name, " product held"}, product, vecs[i].product);
    end

    // Restart after 10 shifts of 7x9 with 6x4.
    loadOperands(32'd7, 32'd9);
    checkOutput("7x9 M after load", 64'(m), 64'd1);
    for (int i = 0; i < 10; i++) loopIteration(k_seen, m_seen);
    applyStimulus(32'd6, 32'd4, shifts_at_k, k_count, ad_count, done);
    checkOutput("restart product", product, 64'h18);
    checkOutput("restart K shift index", 64'(shifts_at_k), 64'(W));

    // Reset during loop cycle 20, while a shift is also being requested.
    loadOperands(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) loopIteration(k_seen, m_seen);
    ad = m;
    tick();
    ad    = 1'b0;
    sh    = 1'b1;
    rst_n = 1'b0;
    tick();
    sh    = 1'b0;
    rst_n = 1'b1;
    checkOutput("mid reset product", product, '0);
    checkOutput("mid reset K", 64'(k), 64'd0);
    checkOutput("mid reset M", 64'(m), 64'd0);
    applyStimulus(32'd2, 32'd2, shifts_at_k, k_count, ad_count, done);
    checkOutput("2x2 after reset", product, 64'd4);
    checkOutput("2x2 K shift index", 64'(shifts_at_k), 64'(W));

    // Ad and Sh together: add first, then shift the whole register.
    loadOperands(32'd3, 32'd1);
    ad = 1'b1;
    sh = 1'b1;
    tick();
    ad = 1'b0;
    sh = 1'b0;
    checkOutput("ad+sh product", product, 64'h0000_0001_8000_0000);

    // Extra shifts past W wrap the counter so K reappears on shift 2W.
    loadOperands(32'd1, 32'd1);
    k_count = 0;
    shifts_at_k = 0;
    for (int i = 1; i <= 2 * W; i++) begin
      sh = 1'b1;
      if (k) begin
        k_count++;
        shifts_at_k = i;
      end
      tick();
    end
    sh = 1'b0;
    checkOutput("wrap K count", 64'(k_count), 64'd2);
    checkOutput("wrap last K shift", 64'(shifts_at_k), 64'(2 * W));

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/mul_shift_add_datapath.md
# mul_shift_add_datapath

Datapath half of the sequential shift-and-add multiplier: holds the multiplicand, the combined accumulator/multiplier register and the bit counter. It executes the `Load`, `Ad` and `Sh` strobes issued by the multiplier control FSM. It returns the `M` (current multiplier bit) and `K` (last bit) status back to that FSM. It drives the unsigned 2W-bit product consumed by the HI/LO register stage.

## Interface
- `WIDTH`, default 32: operand width W; must be ≥ 2.
- `Clk`  in  1  rising-edge clock for all state.
- `Rst_n`  in  1  synchronous, active-low reset.
- `Load`  in  1  capture operands and start a new product.
- `Ad`  in  1  add the multiplicand into the accumulator upper half.
- `Sh`  in  1  shift the accumulator right one bit and advance the counter.
- `Mcand`  in  W  multiplicand, unsigned; sampled only on `Load`.
- `Mplier`  in  W  multiplier, unsigned; sampled only on `Load`.
- `M`  out  1  accumulator bit 0 (the current multiplier bit), combinational from the register.
- `K`  out  1  high while count == W-1, combinational from the counter.
- `Product`  out  2W  accumulator bits [2W-1:0].

## Operation
- State:
  - `mcand_q` is W bits.
  - `acc_q` is 2W+1 bits: [2W] is the add carry, [2W-1:W] is the partial sum, [W-1:0] is the remaining multiplier.
  - `cnt_q` is clog2(W) bits.
- Priority is `Rst_n` low > `Load` > `Ad`/`Sh`.
- Reset: `mcand_q`, `acc_q` and `cnt_q` clear to 0. Outputs after reset: `M`=0, `K`=0, `Product`=0.
- `Load`:
  - `mcand_q` <= `Mcand`.
  - `acc_q` <= {(W+1)'b0, `Mplier`}.
  - `cnt_q` <= 0.
  - `Ad` and `Sh` are ignored in the same cycle.
- `Ad` only: `acc_q[2W:W]` <= `acc_q[2W-1:W]` + `mcand_q`, a (W+1)-bit result that keeps the carry. Lower half is unchanged.
- `Sh` only:
  - `acc_q` <= `acc_q` >> 1 with a zero fill.
  - `cnt_q` <= `cnt_q` + 1, wrapping modulo 2^clog2(W).
- `Ad` and `Sh` together (control never issues this; behaviour is defined anyway): the add result is formed first, then the whole register is shifted right. `cnt_q` increments.
- Idle (no strobe): all registers hold. `Product` stays stable until the next `Load` or reset.
- Extra `Sh` after W shifts: shifting continues and the counter wraps. The product is then invalid; this is not an error.
- Arithmetic is unsigned only. The upper bit of `acc_q` is always 0 when `Ad` fires under the legal control sequence, so no overflow is possible.

## Timing
- Control sequence per multiplier bit: one `Ad`-or-idle cycle (S1), then one `Sh` cycle (S2). The controller samples `K` during the `Sh` cycle.
- `K` is high during the Sh cycle that performs the W-th shift. The controller therefore leaves the loop after exactly W shifts. `K` falls the cycle after that shift (count wraps to 0).
- `M` reflects the shifted value one cycle after each `Sh` or `Load`. It is valid for the controller's S1 decision with zero additional latency.
- Operation latency: `Load` cycle + 2W loop cycles. `Product` is final on the edge ending the last `Sh`, the same cycle the controller enters Done.
- `Load` mid-operation: the current product is abandoned and the new operands are captured on that edge.
- Reset mid-operation: everything clears on the next rising edge with `Rst_n` low.

## Structure
- Shared package `mul_pkg`:
  - `MUL_WIDTH` default (32).
  - `MUL_CNT_W` = clog2(`MUL_WIDTH`).
  - `MUL_ACC_W` = 2·`MUL_WIDTH`+1.
  - Product typedef reused by the HI/LO stage.
- One sub-module, `mul_bit_counter`: owns `cnt_q`, with ports `Clk`, `Rst_n`, `Load` (clear), `Sh` (increment) and output `K`.
- The accumulator and adder stay in the top module.

## Test plan
- Reset then idle: `Rst_n`=0 for 2 cycles, no strobes → `Product`=0, `M`=0, `K`=0 and held.
- 3×5: `Mcand`=0x00000003, `Mplier`=0x00000005, driven by the reference controller sequence → `Product`=0x000000000000000F after 32 shifts. `K` is high on exactly the 32nd `Sh` cycle.
- Max operands: 0xFFFFFFFF × 0xFFFFFFFF → `Product`=0xFFFFFFFE00000001. Checks carry bit [2W] propagation on every `Ad`.
- Zero multiplier: `Mplier`=0, `Mcand`=0xDEADBEEF → `M` is never high, no `Ad` issued, `Product`=0.
- Restart: `Load` asserted after 10 shifts of 7×9 with new operands 6×4 → `Product`=0x18. No residue from the first operation.
- Reset mid-operation: `Rst_n`=0 during loop cycle 20 → next edge `Product`=0, `K`=0. A following `Load` of 2×2 yields 4.
